// File: rtl/alimentare_pkg.sv
// Shared constants for the operand feeder: FSM state encodings and the
// width of the optional completed-operation counter (ALIMENTARE_CONTOR_EN).
package alimentare_pkg;

  typedef logic [1:0] stare_t;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  localparam int unsigned CONTOR_W = 16;

endpackage

// File: rtl/alimentare_operanzi_if.sv
// Operand input and result output handshakes of alimentare_operanzi.
// master = producer/consumer side, slave = the feeder itself.
interface alimentare_operanzi_if #(
  parameter int unsigned x = 8
);

  logic           in_valid;
  logic           in_ready;
  logic [x-1:0]   in_a;
  logic [x-1:0]   in_b;
  logic           res_valid;
  logic           res_ready;
  logic [2*x-1:0] res;

  modport master (
    output in_valid, in_a, in_b, res_ready,
    input  in_ready, res_valid, res
  );

  modport slave (
    input  in_valid, in_a, in_b, res_ready,
    output in_ready, res_valid, res
  );

endinterface

// File: rtl/alimentare_operanzi_fifo.sv
// fifo_operanzi: operand-pair FIFO. Head is presented combinationally on
// dout; a push into an empty FIFO is only visible after the next edge.
module fifo_operanzi #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_q[AW-1:0]];

  // Read/write pointer update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since empty masks them.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/alimentare_operanzi.sv
// alimentare_operanzi: feeds queued operand pairs to a multi-cycle
// multiplier one at a time and holds each product until consumed.
// Optional macro ALIMENTARE_CONTOR_EN adds the nr_op capture counter.
module alimentare_operanzi
  import alimentare_pkg::*;
#(
  parameter int unsigned x     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  alimentare_operanzi_if.slave bus,
  output logic                 start,
  output logic [x-1:0]         OpA,
  output logic [x-1:0]         OpB,
  input  logic                 busy,
  input  logic                 ready,
  input  logic [2*x-1:0]       mul
`ifdef ALIMENTARE_CONTOR_EN
  ,
  output logic [CONTOR_W-1:0]  nr_op
`endif
);

  stare_t         state_q, state_d;
  logic [x-1:0]   opa_q, opb_q;
  logic [2*x-1:0] res_q;
  logic           res_valid_q;
  logic [2*x-1:0] head;
  logic           full, empty;
  logic           issue;
  logic           capture;

  assign issue   = (state_q == IDLE) && !empty && !res_valid_q && !busy;
  assign capture = (state_q == WAIT) && ready;

  fifo_operanzi #(
    .WIDTH (2*x),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.in_valid),
    .din   ({bus.in_a, bus.in_b}),
    .pop   (issue),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign bus.in_ready  = !full;
  assign bus.res_valid = res_valid_q;
  assign bus.res       = res_q;
  assign start         = (state_q == START);
  assign OpA           = opa_q;
  assign OpB           = opb_q;

  // Next-state logic: issue, one-cycle launch, wait for the product.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (issue) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Operand registers load only on pop, so they stay put through START/WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opa_q <= '0;
      opb_q <= '0;
    end else if (issue) begin
      opa_q <= head[2*x-1:x];
      opb_q <= head[x-1:0];
    end
  end

  // Result capture in WAIT; valid clears once the consumer takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_q       <= '0;
      res_valid_q <= 1'b0;
    end else if (capture) begin
      res_q       <= mul;
      res_valid_q <= 1'b1;
    end else if (res_valid_q && bus.res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

`ifdef ALIMENTARE_CONTOR_EN
  logic [CONTOR_W-1:0] nr_op_q;

  // Completed-capture counter, wraps naturally at its width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        nr_op_q <= '0;
    else if (capture) nr_op_q <= nr_op_q + CONTOR_W'(1);
  end

  assign nr_op = nr_op_q;
`endif

endmodule

// File: tb/tb_alimentare_operanzi.sv
// Scoreboard bench for alimentare_operanzi with a behavioural multiplier.
module tb_alimentare_operanzi;

  localparam int unsigned X = 8;
  localparam int unsigned D = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           start, busy, ready;
  logic           m_ready, s_ready;
  logic [X-1:0]   OpA, OpB;
  logic [2*X-1:0] mul, m_mul, s_mul;
`ifdef ALIMENTARE_CONTOR_EN
  logic [15:0]    nr_op;
`endif

  always #5 clk = ~clk;

  assign ready = m_ready | s_ready;
  assign mul   = s_ready ? s_mul : m_mul;

  alimentare_operanzi_if #(.x(X)) bus ();

  alimentare_operanzi #(.x(X), .DEPTH(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .start (start),
    .OpA   (OpA),
    .OpB   (OpB),
    .busy  (busy),
    .ready (ready),
    .mul   (mul)
`ifdef ALIMENTARE_CONTOR_EN
    ,
    .nr_op (nr_op)
`endif
  );

  int             n_chk = 0;
  int             n_bad = 0;
  int             lat = 8;
  int             start_cnt = 0;
  int             res_cnt = 0;
  int             rv_cycles = 0;
  logic [63:0]    exp_res [$];
  logic [15:0]    exp_ops [$];
  logic [15:0]    e_op;
  logic [63:0]    e_res;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: samples at negedge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_ops.delete();
        exp_res.delete();
      end else begin
        if (bus.in_valid && bus.in_ready) begin
          exp_ops.push_back({bus.in_a, bus.in_b});
          exp_res.push_back(64'(bus.in_a) * 64'(bus.in_b));
        end
        if (start) begin
          start_cnt++;
          check_val("start_blocked", {62'd0, busy, bus.res_valid}, 64'd0);
          if (exp_ops.size() == 0) check_val("start_unexpected", 64'd1, 64'd0);
          else begin
            e_op = exp_ops.pop_front();
            check_val("OpA", 64'(OpA), 64'(e_op[15:8]));
            check_val("OpB", 64'(OpB), 64'(e_op[7:0]));
          end
        end
        if (bus.res_valid) rv_cycles++;
        if (bus.res_valid && bus.res_ready) begin
          res_cnt++;
          if (exp_res.size() == 0) check_val("res_unexpected", 64'd1, 64'd0);
          else begin
            e_res = exp_res.pop_front();
            check_val("res", 64'(bus.res), e_res);
          end
        end
      end
    end
  end

  // Multiplier model: busy after launch, one-cycle ready pulse after lat cycles.
  initial begin
    logic [X-1:0] pa, pb;
    m_ready = 1'b0;
    busy    = 1'b0;
    m_mul   = '0;
    forever begin
      @(negedge clk);
      if (start) begin
        pa = OpA;
        pb = OpB;
        @(posedge clk);
        #2 busy = 1'b1;
        repeat (lat - 1) @(posedge clk);
        #2;
        m_ready = 1'b1;
        m_mul   = 16'(pa) * 16'(pb);
        busy    = 1'b0;
        @(posedge clk);
        #2 m_ready = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Caller is at posedge+2; returns at posedge+2 after the accepting edge.
  task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check_val("push_accept", 64'(ok), 64'd1);
    @(posedge clk);
    #2;
  endtask

  task automatic wait_res(input int target, input int budget, input string tag);
    for (int i = 0; i < budget && res_cnt < target; i++) @(negedge clk);
    check_val(tag, 64'(res_cnt >= target), 64'd1);
  endtask

  initial begin
    int s0, r0, c0;
    bit seen;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    bus.res_ready = 1'b0;
    s_ready      = 1'b0;
    s_mul        = '0;

    repeat (2) @(negedge clk);
    check_val("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check_val("rst_start", 64'(start), 64'd0);
    check_val("rst_OpA", 64'(OpA), 64'd0);
    check_val("rst_OpB", 64'(OpB), 64'd0);
    check_val("rst_res", 64'(bus.res), 64'd0);
    check_val("rst_res_valid", 64'(bus.res_valid), 64'd0);
    @(posedge clk);
    #2 reset = 1'b0;

    // Single operation, consumer always ready.
    lat = 8;
    bus.res_ready = 1'b1;
    s0 = start_cnt; r0 = rv_cycles; c0 = res_cnt;
    push_pair(8'd3, 8'd5);
    bus.in_valid = 1'b0;
    wait_res(c0 + 1, 100, "A_done");
    repeat (3) @(posedge clk);
    #2;
    check_val("A_starts", 64'(start_cnt - s0), 64'd1);
    check_val("A_rv_cycles", 64'(rv_cycles - r0), 64'd1);
    check_val("A_res_hold", 64'(bus.res), 64'd15);

    // Back-pressured result blocks the next launch.
    bus.res_ready = 1'b0;
    lat = 3;
    c0 = res_cnt;
    push_pair(8'd255, 8'd255);
    push_pair(8'd2, 8'd7);
    bus.in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.res_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check_val("B_first_valid", 64'(seen), 64'd1);
    s0 = start_cnt;
    repeat (20) @(negedge clk);
    check_val("B_no_start", 64'(start_cnt - s0), 64'd0);
    check_val("B_res_held", 64'(bus.res), 64'd65025);
    check_val("B_valid_held", 64'(bus.res_valid), 64'd1);
    @(posedge clk);
    #2 bus.res_ready = 1'b1;
    wait_res(c0 + 2, 100, "B_done");
    repeat (2) @(negedge clk);
    check_val("B_res_last", 64'(bus.res), 64'd14);
    check_val("B_valid_clear", 64'(bus.res_valid), 64'd0);

    // Spurious ready while idle is ignored.
    @(posedge clk);
    #2 s_ready = 1'b1;
    s_mul = 16'd1234;
    @(posedge clk);
    #2 s_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_val("E_res", 64'(bus.res), 64'd14);
    check_val("E_valid", 64'(bus.res_valid), 64'd0);

    // Five back-to-back pushes against a stalled multiplier.
    lat = 30;
    c0 = res_cnt;
    @(posedge clk);
    #2;
    for (int k = 0; k < 5; k++) push_pair(8'(10 + k), 8'(20 + k));
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_val("C_full", 64'(bus.in_ready), 64'd0);
    wait_res(c0 + 5, 800, "C_done");
`ifdef ALIMENTARE_CONTOR_EN
    @(negedge clk);
    check_val("cnt_ops", 64'(nr_op), 64'd8);
`endif

    // Reset during WAIT discards the operation; late ready ignored.
    lat = 10;
    c0 = res_cnt; s0 = start_cnt;
    @(posedge clk);
    #2;
    push_pair(8'd9, 8'd9);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 50 && start_cnt == s0; i++) @(negedge clk);
    check_val("D_started", 64'(start_cnt - s0), 64'd1);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1 check_val("D_async_OpA", 64'(OpA), 64'd0);
    #5 reset = 1'b0;
    repeat (20) @(negedge clk);
    check_val("D_res_valid", 64'(bus.res_valid), 64'd0);
    check_val("D_res", 64'(bus.res), 64'd0);
    check_val("D_in_ready", 64'(bus.in_ready), 64'd1);
    check_val("D_no_capture", 64'(res_cnt - c0), 64'd0);
    check_val("D_no_restart", 64'(start_cnt - s0), 64'd1);
`ifdef ALIMENTARE_CONTOR_EN
    check_val("cnt_reset", 64'(nr_op), 64'd0);
`endif
    check_val("final_queue", 64'(exp_res.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
